vip_dataflow_sched: RTL and testbench

//   Start/done sequencer for the 3-stage video dataflow region: AXIvideo2Mat (P0) -> Loop_loop_height (P1) -> Mat2AXIvideo (P2).

---
 rtl/vip_dataflow_sched_if.sv | 37 +++
 rtl/vip_dataflow_sched.sv | 80 ++++++++
 tb/tb_vip_dataflow_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_dataflow_sched_if.sv
// Handshake bundle between the dataflow sequencer and its three stages plus top-level control.
// master is the sequencer side, slave is the environment (top controller and stages).
interface vip_dataflow_sched_if #(
    parameter int FCNT_W = 16
);
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic              p0_start, p1_start, p2_start;
    logic              p0_ready, p1_ready, p2_ready;
    logic              p0_done,  p1_done,  p2_done;
    logic              p0_idle,  p1_idle,  p2_idle;
    logic [FCNT_W-1:0] frame_cnt;
    logic [3:0]        tok01_lvl;
    logic [3:0]        tok12_lvl;
    logic              stall_flag;
    logic              stall_clr;

    modport master (
        input  ap_start, p0_ready, p1_ready, p2_ready,
               p0_done, p1_done, p2_done,
               p0_idle, p1_idle, p2_idle, stall_clr,
        output ap_ready, ap_done, ap_idle,
               p0_start, p1_start, p2_start,
               frame_cnt, tok01_lvl, tok12_lvl, stall_flag
    );

    modport slave (
        output ap_start, p0_ready, p1_ready, p2_ready,
               p0_done, p1_done, p2_done,
               p0_idle, p1_idle, p2_idle, stall_clr,
        input  ap_ready, ap_done, ap_idle,
               p0_start, p1_start, p2_start,
               frame_cnt, tok01_lvl, tok12_lvl, stall_flag
    );
endinterface

// File: rtl/vip_dataflow_sched.sv
// Start/done sequencer for P0->P1->P2: stage starts are combinational from token levels; ap_done/ap_idle lag one cycle.
// Backpressure: a full token counter drops the upstream start (and ap_ready) until the downstream stage accepts.
module vip_dataflow_sched #(
    parameter int START_DEPTH = 2,
    parameter int FCNT_W      = 16,
    parameter int WD_W        = 20,
    parameter int WD_LIMIT    = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    vip_dataflow_sched_if.master  bus
);
    localparam logic [3:0]      DEPTH  = 4'(START_DEPTH);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_LIMIT);

    logic [3:0]        tok01, tok12;
    logic [4:0]        pend;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic [FCNT_W-1:0] frame_cnt;
    logic              ap_done_q, ap_idle_q, stall_q;
    logic              p0_fire, p1_fire, p2_fire, progress;

    assign bus.p0_start = bus.ap_start & (tok01 < DEPTH);
    assign bus.p1_start = (tok01 != 4'd0) & (tok12 < DEPTH);
    assign bus.p2_start = (tok12 != 4'd0);
    assign bus.ap_ready = p0_fire;

    assign p0_fire  = bus.p0_start & bus.p0_ready;
    assign p1_fire  = bus.p1_start & bus.p1_ready;
    assign p2_fire  = bus.p2_start & bus.p2_ready;
    assign progress = p0_fire | p1_fire | p2_fire |
                      bus.p0_done | bus.p1_done | bus.p2_done;

    assign bus.ap_done    = ap_done_q;
    assign bus.ap_idle    = ap_idle_q;
    assign bus.frame_cnt  = frame_cnt;
    assign bus.tok01_lvl  = tok01;
    assign bus.tok12_lvl  = tok12;
    assign bus.stall_flag = stall_q;

    // Watchdog only counts while a frame is in flight and nothing moves.
    always_comb begin
        wd_nxt = wd_cnt;
        if (bus.stall_clr || progress || (pend == 5'd0)) begin
            wd_nxt = '0;
        end else if (wd_cnt != '1) begin
            wd_nxt = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tok01     <= 4'd0;
            tok12     <= 4'd0;
            pend      <= 5'd0;
            wd_cnt    <= '0;
            frame_cnt <= '0;
            ap_done_q <= 1'b0;
            ap_idle_q <= 1'b1;
            stall_q   <= 1'b0;
        end else begin
            // Simultaneous increment and decrement cancel out.
            tok01     <= tok01 + 4'(p0_fire) - 4'(p1_fire);
            tok12     <= tok12 + 4'(p1_fire) - 4'(p2_fire);
            pend      <= pend + 5'(p0_fire) - 5'(bus.p2_done);
            wd_cnt    <= wd_nxt;
            ap_done_q <= bus.p2_done;
            if (bus.p2_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            ap_idle_q <= bus.p0_idle & bus.p1_idle & bus.p2_idle &
                         (tok01 == 4'd0) & (tok12 == 4'd0) & ~bus.ap_start;
            if (bus.stall_clr) begin
                stall_q <= 1'b0;
            end else if (wd_nxt >= WD_LIM) begin
                stall_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vip_dataflow_sched.sv
module tb_vip_dataflow_sched;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    vip_dataflow_sched_if #(.FCNT_W(4)) bus ();

    vip_dataflow_sched #(
        .START_DEPTH(2),
        .FCNT_W     (4),
        .WD_W       (20),
        .WD_LIMIT   (100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ap_start;
        logic [2:0] rdy;
        logic [2:0] done;
        logic [2:0] idle;
        logic       e_ap_ready;
        logic [2:0] e_start;
        logic [3:0] e_t01;
        logic [3:0] e_t12;
        logic       e_done;
        logic       e_idle;
        logic [3:0] e_fcnt;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1ns after the edge, token bound checked every cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        chk("tok01_bound", 32'(bus.tok01_lvl <= 4'd2), 32'd1);
        chk("tok12_bound", 32'(bus.tok12_lvl <= 4'd2), 32'd1);
    endtask

    task automatic drive(input logic st, input logic [2:0] rdy, input logic [2:0] dn,
                         input logic [2:0] idl);
        bus.ap_start = st;
        bus.p0_ready = rdy[0];
        bus.p1_ready = rdy[1];
        bus.p2_ready = rdy[2];
        bus.p0_done  = dn[0];
        bus.p1_done  = dn[1];
        bus.p2_done  = dn[2];
        bus.p0_idle  = idl[0];
        bus.p1_idle  = idl[1];
        bus.p2_idle  = idl[2];
    endtask

    // One frame through an empty pipeline: every stage accepts in the cycle its start appears.
    task automatic frame(input int dly, output int pulses, output logic rdy0,
                         output logic s1, output logic s2);
        pulses = 0;
        drive(1'b1, 3'b001, 3'b000, 3'b111);
        #1; rdy0 = bus.ap_ready;
        tick();
        drive(1'b0, 3'b010, 3'b000, 3'b111);
        #1; s1 = bus.p1_start;
        tick();
        drive(1'b0, 3'b100, 3'b000, 3'b011);
        #1; s2 = bus.p2_start;
        tick();
        drive(1'b0, 3'b000, 3'b000, 3'b011);
        repeat (dly) begin
            #1; pulses += int'(bus.ap_done);
            tick();
        end
        drive(1'b0, 3'b000, 3'b100, 3'b111);
        #1; pulses += int'(bus.ap_done);
        tick();
        drive(1'b0, 3'b000, 3'b000, 3'b111);
        repeat (3) begin
            #1; pulses += int'(bus.ap_done);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int   pulses;
        int   total;
        logic r0, s1, s2;

        checks = 0;
        errors = 0;
        //           st  rdy     done    idle    rdy  start   t01 t12 dn  idl fcnt
        vt[0]  = '{1'b1, 3'b001, 3'b000, 3'b111, 1'b1, 3'b001, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0};
        vt[1]  = '{1'b0, 3'b010, 3'b000, 3'b111, 1'b0, 3'b010, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0};
        vt[2]  = '{1'b0, 3'b100, 3'b000, 3'b111, 1'b0, 3'b100, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0};
        vt[3]  = '{1'b0, 3'b000, 3'b100, 3'b111, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0};
        vt[4]  = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1};
        vt[5]  = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1};
        vt[6]  = '{1'b1, 3'b001, 3'b000, 3'b111, 1'b1, 3'b001, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1};
        vt[7]  = '{1'b1, 3'b011, 3'b000, 3'b111, 1'b1, 3'b011, 4'd1, 4'd0, 1'b0, 1'b0, 4'd1};
        vt[8]  = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b110, 4'd1, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[9]  = '{1'b1, 3'b001, 3'b000, 3'b111, 1'b1, 3'b111, 4'd1, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[10] = '{1'b1, 3'b001, 3'b000, 3'b111, 1'b0, 3'b110, 4'd2, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[11] = '{1'b1, 3'b001, 3'b000, 3'b111, 1'b0, 3'b110, 4'd2, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[12] = '{1'b1, 3'b011, 3'b000, 3'b111, 1'b0, 3'b110, 4'd2, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[13] = '{1'b1, 3'b001, 3'b000, 3'b111, 1'b1, 3'b101, 4'd1, 4'd2, 1'b0, 1'b0, 4'd1};
        vt[14] = '{1'b0, 3'b100, 3'b000, 3'b011, 1'b0, 3'b100, 4'd2, 4'd2, 1'b0, 1'b0, 4'd1};
        vt[15] = '{1'b0, 3'b110, 3'b000, 3'b011, 1'b0, 3'b110, 4'd2, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[16] = '{1'b0, 3'b110, 3'b000, 3'b011, 1'b0, 3'b110, 4'd1, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[17] = '{1'b0, 3'b100, 3'b000, 3'b011, 1'b0, 3'b100, 4'd0, 4'd1, 1'b0, 1'b0, 4'd1};
        vt[18] = '{1'b0, 3'b000, 3'b100, 3'b011, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1};
        vt[19] = '{1'b0, 3'b000, 3'b100, 3'b011, 1'b0, 3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2};
        vt[20] = '{1'b0, 3'b000, 3'b100, 3'b011, 1'b0, 3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd3};
        vt[21] = '{1'b0, 3'b000, 3'b100, 3'b111, 1'b0, 3'b000, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4};
        vt[22] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5};
        vt[23] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5};

        reset         = 1'b1;
        bus.stall_clr = 1'b0;
        drive(1'b0, 3'b000, 3'b000, 3'b111);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_ap_done",   32'(bus.ap_done),    32'd0);
        chk("rst_ap_idle",   32'(bus.ap_idle),    32'd1);
        chk("rst_stall",     32'(bus.stall_flag), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt),  32'd0);
        chk("rst_tok01",     32'(bus.tok01_lvl),  32'd0);
        chk("rst_tok12",     32'(bus.tok12_lvl),  32'd0);
        chk("rst_starts",    32'({bus.p2_start, bus.p1_start, bus.p0_start}), 32'd0);
        tick();

        // Table: single frame, simultaneous inc/dec, back-pressure with full counters, drain.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].ap_start, vt[i].rdy, vt[i].done, vt[i].idle);
            #1;
            chk($sformatf("v%0d_ap_ready", i), 32'(bus.ap_ready), 32'(vt[i].e_ap_ready));
            chk($sformatf("v%0d_starts", i),
                32'({bus.p2_start, bus.p1_start, bus.p0_start}), 32'(vt[i].e_start));
            chk($sformatf("v%0d_tok01", i), 32'(bus.tok01_lvl), 32'(vt[i].e_t01));
            chk($sformatf("v%0d_tok12", i), 32'(bus.tok12_lvl), 32'(vt[i].e_t12));
            chk($sformatf("v%0d_ap_done", i), 32'(bus.ap_done), 32'(vt[i].e_done));
            chk($sformatf("v%0d_ap_idle", i), 32'(bus.ap_idle), 32'(vt[i].e_idle));
            chk($sformatf("v%0d_frame_cnt", i), 32'(bus.frame_cnt), 32'(vt[i].e_fcnt));
            tick();
        end

        // Watchdog with nothing in flight never fires.
        drive(1'b0, 3'b000, 3'b000, 3'b111);
        repeat (150) tick();
        #1 chk("wd_pend0_quiet", 32'(bus.stall_flag), 32'd0);

        // One frame in flight, then silence: flag sets on the 100th quiet edge.
        drive(1'b1, 3'b001, 3'b000, 3'b111);
        tick();
        drive(1'b0, 3'b000, 3'b000, 3'b111);
        repeat (99) tick();
        #1 chk("wd_before_limit", 32'(bus.stall_flag), 32'd0);
        tick();
        #1 chk("wd_at_limit", 32'(bus.stall_flag), 32'd1);
        repeat (10) tick();
        #1 chk("wd_sticky", 32'(bus.stall_flag), 32'd1);
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        #1 chk("wd_cleared", 32'(bus.stall_flag), 32'd0);
        repeat (99) tick();
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        #1 chk("wd_clr_priority", 32'(bus.stall_flag), 32'd0);
        tick();
        #1 chk("wd_restarted", 32'(bus.stall_flag), 32'd0);

        // Build tok01=2, tok12=1, then reset mid-frame.
        drive(1'b0, 3'b010, 3'b000, 3'b111);
        tick();
        drive(1'b1, 3'b001, 3'b000, 3'b111);
        tick();
        tick();
        drive(1'b0, 3'b000, 3'b000, 3'b011);
        #1;
        chk("mr_pre_tok01", 32'(bus.tok01_lvl), 32'd2);
        chk("mr_pre_tok12", 32'(bus.tok12_lvl), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_tok01",     32'(bus.tok01_lvl),  32'd0);
        chk("mr_tok12",     32'(bus.tok12_lvl),  32'd0);
        chk("mr_ap_idle",   32'(bus.ap_idle),    32'd1);
        chk("mr_ap_done",   32'(bus.ap_done),    32'd0);
        chk("mr_frame_cnt", 32'(bus.frame_cnt),  32'd0);
        chk("mr_stall",     32'(bus.stall_flag), 32'd0);
        drive(1'b0, 3'b000, 3'b000, 3'b111);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mr_no_start_%0d", c),
                32'({bus.ap_ready, bus.p2_start, bus.p1_start, bus.p0_start}), 32'd0);
            tick();
        end

        // Single frame, P2 done ~50 cycles after its start.
        frame(49, pulses, r0, s1, s2);
        chk("sf_ap_ready_c0", 32'(r0), 32'd1);
        chk("sf_p1_start",    32'(s1), 32'd1);
        chk("sf_p2_start",    32'(s2), 32'd1);
        chk("sf_done_pulses", 32'(pulses), 32'd1);
        #1;
        chk("sf_frame_cnt",   32'(bus.frame_cnt), 32'd1);
        chk("sf_ap_idle",     32'(bus.ap_idle),   32'd1);
        tick();

        // Frame counter wrap at 4 bits: frames 2..17.
        total = 0;
        for (int f = 0; f < 14; f++) begin
            frame(2, pulses, r0, s1, s2);
            total += pulses;
        end
        #1 chk("wrap_fcnt_15", 32'(bus.frame_cnt), 32'd15);
        tick();
        frame(2, pulses, r0, s1, s2);
        total += pulses;
        #1 chk("wrap_fcnt_0", 32'(bus.frame_cnt), 32'd0);
        tick();
        frame(2, pulses, r0, s1, s2);
        total += pulses;
        #1 chk("wrap_fcnt_1", 32'(bus.frame_cnt), 32'd1);
        chk("wrap_done_pulses", 32'(total), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
